uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that is the downstream partner of the team's UART transmitter. It samples the transmitter's `tx_dout` line (8N1 framing, idle high, LSB first) and recovers each byte. It presents the byte through a one-entry valid/ready holding register and flags framing errors and overruns. It sits between the serial pin or loopback wire and the byte-consuming control logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. Must be ≥ 1. The default of 1 matches the transmitter's one-bit-per-clock output.
- `HALF`, derived as (CLKS_PER_BIT-1)/2 (integer division): offset of the mid-bit sample point.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_din`, in, 1: serial input, asynchronous to `clk`, idle high.
- `rx_ready`, in, 1: consumer accepts `data_recv` on a cycle where `rx_valid` is also high.
- `data_recv`, out, 8: last correctly received byte.
- `rx_valid`, out, 1: `data_recv` holds an unconsumed byte.
- `framing_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a good frame is dropped because the holding register is full.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer:** two flops, both reset to 1. `rx_sync` is `rx_din` delayed by 2 cycles. All decisions use `rx_sync`.
- **FSM states:** IDLE, START, DATA, STOP, RECOVER.
- **Counters:** `clk_cnt` is wide enough for CLKS_PER_BIT-1. `bit_idx` is 3 bits. The shift register is 8 bits.
- **IDLE:** the first cycle with `rx_sync`=0 is T0.
  - If HALF=0, T0 itself confirms the start bit and the FSM goes to DATA.
  - Otherwise it goes to START.
- **START:** samples at T0+HALF.
  - If 0, go to DATA.
  - If 1, it was a glitch: return to IDLE with no flags.
- **DATA:** bit k (k=0..7) is sampled at T0+HALF+(k+1)·CLKS_PER_BIT and shifted in LSB-first. After bit 7, go to STOP.
- **STOP:** samples at T0+HALF+9·CLKS_PER_BIT.
  - If 1 (good frame):
    - Holding register empty, or consumed on this same edge: load `data_recv` and set `rx_valid`.
    - Otherwise: keep the old byte, pulse `overrun`, and leave `rx_valid` high.
    - Return to IDLE.
  - If 0: discard the byte, pulse `framing_err`, go to RECOVER.
- **RECOVER:** wait until `rx_sync`=1, then go to IDLE. This prevents a break condition from being decoded as repeated frames.
- **Handshake:**
  - `rx_valid` falls on the edge where `rx_valid`&`rx_ready` is true, unless a new byte loads on that same edge, in which case it stays high.
  - `rx_ready` has no effect while `rx_valid`=0.
- **Reset:**
  - Clears the FSM to IDLE, both counters, and the shift register.
  - Outputs: `data_recv`=0, `rx_valid`=0, `framing_err`=0, `overrun`=0, `busy`=0.
  - Synchronizer flops go to 1.
  - Reset mid-frame aborts the frame; partial bits are never delivered and no flag is raised.

## Timing
- **Sample latency:** pin to `rx_sync` is 2 cycles.
- **Frame latency:** with CLKS_PER_BIT=1, a start bit on `rx_din` at cycle S gives T0=S+2. The stop sample is at S+11, and `rx_valid` and `data_recv` update on that edge, so they are visible from S+12.
- **General case:** `rx_valid` rises 1 cycle after the stop-sample edge, i.e. T0+HALF+9·CLKS_PER_BIT+1.
- **Flag width:** `framing_err` and `overrun` are high for exactly one cycle, aligned with the stop-sample edge.
- **Back-to-back frames:** the receiver returns to IDLE on the stop-sample edge, so a start bit immediately following the stop bit is detected.
- **`busy`:** rises the cycle after T0 and falls the cycle after the return to IDLE.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `rx_din`=1 → all outputs are 0 and `busy`=0.
- **Basic receive, loopback from the transmitter (CLKS_PER_BIT=1):** send 0xD3 → `rx_valid` rises 12 cycles after the start bit, `data_recv`=0xD3. Assert `rx_ready` for 1 cycle → `rx_valid` drops on the next edge.
- **Overrun:** send 0xD3 and then 0x5A back-to-back with `rx_ready`=0 → `data_recv` stays 0xD3, `overrun` pulses once on the second stop sample, `rx_valid` stays 1. Repeat with `rx_ready`=1 on the second stop edge → `data_recv`=0x5A and no `overrun`.
- **Framing error:** frame 0xA5 with the stop bit driven 0, then the line held low for 5 cycles → `framing_err` pulses once, `rx_valid` stays 0, and `busy` stays high until the line returns to 1.
- **Glitch rejection (CLKS_PER_BIT=4):** a 1-cycle low pulse → no `rx_valid`, no flags, back to IDLE. Then a valid 0x3C frame → received correctly.
- **Reset mid-frame:** assert `rst` after 4 data bits of 0xFF → no `rx_valid`. The next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, byte handshake and status flags of the UART receiver
interface uart_rx_if;
    logic       rx_din;
    logic       rx_ready;
    logic [7:0] data_recv;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;
    modport master (output rx_din, rx_ready, input data_recv, rx_valid, framing_err, overrun, busy);
    modport slave  (input rx_din, rx_ready, output data_recv, rx_valid, framing_err, overrun, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ready holding register
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
    state_t        state, state_d;
    logic [1:0]    sync;
    logic          rx_sync;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sample, good, bad, load;
    assign rx_sync = sync[1];
    assign bus.busy = state != IDLE;
    // next state, sample strobe and stop-bit verdict
    always_comb begin
        state_d = state;
        sample = 1'b0;
        good = 1'b0;
        bad = 1'b0;
        case (state)
            IDLE: if (!rx_sync) state_d = HALF == 0 ? DATA : START;
            START: begin
                sample = clk_cnt == CW'(HALF - 1);
                if (sample) state_d = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                sample = clk_cnt == CW'(CLKS_PER_BIT - 1);
                if (sample && bit_idx == 3'd7) state_d = STOP;
            end
            STOP: begin
                sample = clk_cnt == CW'(CLKS_PER_BIT - 1);
                good = sample && rx_sync;
                bad = sample && !rx_sync;
                if (sample) state_d = rx_sync ? IDLE : RECOVER;
            end
            RECOVER: if (rx_sync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        load = good && (!bus.rx_valid || bus.rx_ready);
    end
    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end
    // synchronizer, bit timing, shift register and holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            bus.data_recv <= '0;
            bus.rx_valid <= 1'b0;
            bus.framing_err <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            sync <= {sync[0], bus.rx_din};
            clk_cnt <= (state == IDLE || state == RECOVER || sample) ? '0 : clk_cnt + 1'b1;
            bit_idx <= state == DATA ? bit_idx + 3'(sample) : '0;
            if (state == DATA && sample) shift <= {rx_sync, shift[7:1]};
            if (load) bus.data_recv <= shift;
            bus.rx_valid <= load || (bus.rx_valid && !bus.rx_ready);
            bus.framing_err <= bad;
            bus.overrun <= good && !load;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at one and four clocks per bit
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q1[$];
    logic [7:0] q4[$];
    int fe1 = 0, ov1 = 0, fe4 = 0, ov4 = 0;
    logic pv1 = 1'b0, pr1 = 1'b0, pv4 = 1'b0, pr4 = 1'b0;

    uart_rx_if b1();
    uart_rx_if b4();
    uart_rx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    uart_rx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor for the one-clock-per-bit receiver
    always @(negedge clk) begin
        if (b1.rx_valid && (!pv1 || pr1)) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut1 unexpected byte: got %0h expected none", b1.data_recv);
            end else chk("dut1 data_recv", b1.data_recv, q1.pop_front());
        end
        pv1 = b1.rx_valid;
        pr1 = b1.rx_ready;
        if (b1.framing_err) fe1++;
        if (b1.overrun) ov1++;
    end

    // monitor for the four-clocks-per-bit receiver
    always @(negedge clk) begin
        if (b4.rx_valid && (!pv4 || pr4)) begin
            if (q4.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut4 unexpected byte: got %0h expected none", b4.data_recv);
            end else chk("dut4 data_recv", b4.data_recv, q4.pop_front());
        end
        pv4 = b4.rx_valid;
        pr4 = b4.rx_ready;
        if (b4.framing_err) fe4++;
        if (b4.overrun) ov4++;
    end

    task automatic bit_out(input int which, input logic v, input int n);
        repeat (n) begin
            if (which == 4) b4.rx_din = v;
            else b1.rx_din = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int which, input logic [7:0] d, input logic stop, output int s);
        s = cyc;
        bit_out(which, 1'b0, which);
        for (int i = 0; i < 8; i++) bit_out(which, d[i], which);
        bit_out(which, stop, which);
    endtask

    task automatic accept(input int which);
        @(posedge clk);
        #1;
        if (which == 4) b4.rx_ready = 1'b1;
        else b1.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        b1.rx_ready = 1'b0;
        b4.rx_ready = 1'b0;
        @(negedge clk);
        chk(which == 4 ? "dut4 valid after accept" : "dut1 valid after accept",
            which == 4 ? b4.rx_valid : b1.rx_valid, 0);
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n && (q1.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        chk("scoreboard drained", q1.size() + q4.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        b1.rx_din = 1'b1;
        b4.rx_din = 1'b1;
        b1.rx_ready = 1'b0;
        b4.rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset dut1 data_recv", b1.data_recv, 0);
        chk("reset dut1 rx_valid", b1.rx_valid, 0);
        chk("reset dut1 framing_err", b1.framing_err, 0);
        chk("reset dut1 overrun", b1.overrun, 0);
        chk("reset dut1 busy", b1.busy, 0);
        chk("reset dut4 data_recv", b4.data_recv, 0);
        chk("reset dut4 rx_valid", b4.rx_valid, 0);
        chk("reset dut4 framing_err", b4.framing_err, 0);
        chk("reset dut4 overrun", b4.overrun, 0);
        chk("reset dut4 busy", b4.busy, 0);
        @(posedge clk);
        #1;

        q1.push_back(8'hD3);
        frame(1, 8'hD3, 1'b1, s);
        for (int i = 0; i < 30 && !b1.rx_valid; i++) @(negedge clk);
        chk("dut1 valid latency", cyc - s, 12);
        accept(1);

        q1.push_back(8'hD3);
        frame(1, 8'hD3, 1'b1, s);
        frame(1, 8'h5A, 1'b1, s);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("overrun keeps old byte", b1.data_recv, 8'hD3);
        chk("overrun keeps valid", b1.rx_valid, 1);
        chk("overrun pulses", ov1, 1);
        accept(1);

        q1.push_back(8'hD3);
        q1.push_back(8'h5A);
        frame(1, 8'hD3, 1'b1, s);
        frame(1, 8'h5A, 1'b1, s);
        @(posedge clk);
        #1;
        b1.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        b1.rx_ready = 1'b0;
        @(negedge clk);
        chk("same-edge reload byte", b1.data_recv, 8'h5A);
        chk("same-edge reload valid", b1.rx_valid, 1);
        chk("no overrun on same-edge reload", ov1, 1);
        accept(1);

        frame(1, 8'hA5, 1'b0, s);
        bit_out(1, 1'b0, 5);
        @(negedge clk);
        chk("break keeps busy", b1.busy, 1);
        chk("framing_err pulses", fe1, 1);
        chk("framing frame not delivered", b1.rx_valid, 0);
        @(posedge clk);
        #1;
        b1.rx_din = 1'b1;
        for (int i = 0; i < 10 && b1.busy; i++) @(negedge clk);
        chk("busy clears after break", b1.busy, 0);

        bit_out(4, 1'b0, 1);
        bit_out(4, 1'b1, 12);
        @(negedge clk);
        chk("glitch busy", b4.busy, 0);
        chk("glitch rx_valid", b4.rx_valid, 0);
        chk("glitch framing_err", fe4, 0);
        chk("glitch overrun", ov4, 0);
        @(posedge clk);
        #1;
        q4.push_back(8'h3C);
        frame(4, 8'h3C, 1'b1, s);
        wait_drain(20);

        bit_out(1, 1'b0, 1);
        bit_out(1, 1'b1, 4);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid-frame reset busy", b1.busy, 0);
        chk("mid-frame reset rx_valid", b1.rx_valid, 0);
        @(posedge clk);
        #1;
        q1.push_back(8'h81);
        frame(1, 8'h81, 1'b1, s);
        wait_drain(20);
        repeat (3) @(negedge clk);
        chk("total dut1 framing_err", fe1, 1);
        chk("total dut1 overrun", ov1, 1);
        chk("total dut4 flags", fe4 + ov4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
